// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce; one key_code + key_valid pulse per debounced press.
// Press-to-strobe latency is 3 + DEBOUNCE_CYCLES clocks, with no backpressure. KEY_REPEAT_EN adds held-key auto-repeat.
module keypad_scanner #(
    parameter logic [21:0] SCAN_DIVIDER    = 22'd1000,
    parameter logic [21:0] DEBOUNCE_CYCLES = 22'd48000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd2400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    if (SCAN_DIVIDER < 22'd3) begin : g_bad_divider
        $error("SCAN_DIVIDER must be at least 3");
    end
    if (REPEAT_CYCLES == 24'd0) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be nonzero");
    end

    state_t      state, state_n;
    logic [3:0]  rows_m, rows_s;
    logic [1:0]  col_idx, col_idx_n;
    logic [1:0]  row_idx, row_idx_n;
    logic [21:0] scan_cnt, scan_cnt_n;
    logic [21:0] db_cnt, db_cnt_n;
    logic [3:0]  key_code_n;
    logic        key_valid_n;
    logic        key_held_n;
    logic [1:0]  low_row;
    logic        any_low;
    logic        row_up;

`ifdef KEY_REPEAT_EN
    logic [23:0] rep_cnt, rep_cnt_n;
`endif

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_m <= 4'b1111;
            rows_s <= 4'b1111;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
        end
    end

    assign cols    = ~(4'b0001 << col_idx);
    assign any_low = ~&rows_s;
    assign row_up  = rows_s[row_idx];

    always_comb begin
        low_row = 2'd3;
        if (!rows_s[0])      low_row = 2'd0;
        else if (!rows_s[1]) low_row = 2'd1;
        else if (!rows_s[2]) low_row = 2'd2;
    end

    always_comb begin
        state_n     = state;
        col_idx_n   = col_idx;
        row_idx_n   = row_idx;
        scan_cnt_n  = scan_cnt;
        db_cnt_n    = db_cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
`ifdef KEY_REPEAT_EN
        rep_cnt_n   = rep_cnt;
`endif
        case (state)
            SCAN: begin
                // The first two counts after a column change cover settling plus sync latency.
                if (scan_cnt >= 22'd2 && any_low) begin
                    row_idx_n = low_row;
                    db_cnt_n  = 22'd0;
                    state_n   = DB_PRESS;
                end else if (scan_cnt >= SCAN_DIVIDER - 22'd1) begin
                    col_idx_n  = col_idx + 2'd1;
                    scan_cnt_n = 22'd0;
                end else begin
                    scan_cnt_n = scan_cnt + 22'd1;
                end
            end
            DB_PRESS: begin
                if (row_up) begin
                    col_idx_n  = col_idx + 2'd1;
                    scan_cnt_n = 22'd0;
                    state_n    = SCAN;
                end else if (db_cnt >= DEBOUNCE_CYCLES - 22'd1) begin
                    key_code_n  = key_map(row_idx, col_idx);
                    key_valid_n = 1'b1;
                    key_held_n  = 1'b1;
                    state_n     = HELD;
`ifdef KEY_REPEAT_EN
                    rep_cnt_n   = 24'd0;
`endif
                end else begin
                    db_cnt_n = db_cnt + 22'd1;
                end
            end
            HELD: begin
                if (row_up) begin
                    db_cnt_n = 22'd0;
                    state_n  = DB_RELEASE;
                end
`ifdef KEY_REPEAT_EN
                else if (rep_cnt >= REPEAT_CYCLES - 24'd1) begin
                    key_valid_n = 1'b1;
                    rep_cnt_n   = 24'd0;
                end else begin
                    rep_cnt_n = rep_cnt + 24'd1;
                end
`endif
            end
            default: begin
                if (!row_up) begin
                    db_cnt_n = 22'd0;
                    state_n  = HELD;
`ifdef KEY_REPEAT_EN
                    rep_cnt_n = 24'd0;
`endif
                end else if (db_cnt >= DEBOUNCE_CYCLES - 22'd1) begin
                    key_held_n = 1'b0;
                    col_idx_n  = col_idx + 2'd1;
                    scan_cnt_n = 22'd0;
                    state_n    = SCAN;
                end else begin
                    db_cnt_n = db_cnt + 22'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            scan_cnt  <= 22'd0;
            db_cnt    <= 22'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            scan_cnt  <= scan_cnt_n;
            db_cnt    <= db_cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rep_cnt <= 24'd0;
        else       rep_cnt <= rep_cnt_n;
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, random key choices, timing derived from sync + detect + debounce.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int DB  = 16;
    localparam int LAT = 2 + 1 + DB;   // synchronizer, detect cycle, debounce window
    localparam logic [3:0] LEGEND [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] key_down = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int last_valid_cyc = 0;
    logic [3:0] last_valid_code = 4'h0;
    int rows_fall_cyc = 0;
    int rows_rise_cyc = 0;
    logic [3:0] prev_rows = 4'hF;

    keypad_scanner #(
        .SCAN_DIVIDER   (22'd8),
        .DEBOUNCE_CYCLES(22'd16),
        .REPEAT_CYCLES  (24'd64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            if (|(key_down[r*4 +: 4] & ~cols)) rows[r] = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_rows <= rows;
        if (prev_rows == 4'hF && rows != 4'hF) rows_fall_cyc <= cyc;
        if (prev_rows != 4'hF && rows == 4'hF) rows_rise_cyc <= cyc;
        if (key_valid) begin
            valid_cnt       <= valid_cnt + 1;
            last_valid_cyc  <= cyc;
            last_valid_code <= key_code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] colmask(input int c);
        logic [3:0] m;
        m = 4'b0001 << c;
        return ~m;
    endfunction

    task automatic wait_valid(input int budget, input string tag, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (key_valid) begin
                at = cyc;
                break;
            end
        end
        chk(tag, (at >= 0) ? 1 : 0, 1);
    endtask

    task automatic wait_held_low(input int budget, input string tag, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (!key_held) begin
                at = cyc;
                break;
            end
        end
        chk(tag, (at >= 0) ? 1 : 0, 1);
    endtask

    task automatic wait_cols(input logic [3:0] target, input logic want_eq, input int budget, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if ((cols == target) == want_eq) begin
                found = 1;
                break;
            end
            step(1);
        end
        chk(tag, found, 1);
    endtask

    // Press one key, check the debounced strobe, optionally glitch the release, then release it.
    task automatic run_key(input int r, input int c, input int glitch);
        int n0, at;
        n0 = valid_cnt;
        key_down = 16'd1 << (r*4 + c);
        wait_valid(120, "press_timeout", at);
        chk("press_code", key_code, LEGEND[r*4 + c]);
        chk("press_latency", at - rows_fall_cyc, LAT);
        chk("press_held", key_held, 1);
        chk("press_cols_frozen", cols, colmask(c));
        step(1);
        chk("valid_one_cycle", key_valid, 0);
        if (glitch > 0) begin
            key_down = '0;
            step(glitch);
            key_down = 16'd1 << (r*4 + c);
            step(25);
            chk("glitch_held", key_held, 1);
        end
        step($urandom_range(10, 30));
        chk("press_single_valid", valid_cnt - n0, 1);
        key_down = '0;
        wait_held_low(60, "release_timeout", at);
        chk("release_latency", at - rows_rise_cyc, LAT);
        chk("release_cols", cols, colmask((c + 1) % 4));
    endtask

    initial begin
        int base, at, n0, v0, idx;

        // reset state
        step(3);
        chk("reset_cols", cols, 4'b1110);
        chk("reset_valid", key_valid, 0);
        chk("reset_held", key_held, 0);
        chk("reset_code", key_code, 4'h0);
        reset = 1'b0;
        base = cyc;

        // idle scan: each column driven for 8 clocks in order c0..c3
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("idle_cols", cols, colmask(((cyc - base) / 8) % 4));
        end
        chk("idle_no_valid", valid_cnt, 0);

        // clean press of "5" with a release glitch during HELD
        step($urandom_range(0, 15));
        run_key(1, 1, $urandom_range(2, 10));

        // random single keys at random scan phases
        for (int k = 0; k < 5; k++) begin
            step($urandom_range(0, 20));
            run_key($urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        // bounce on r2/c3 shorter than the debounce window
        n0 = valid_cnt;
        wait_cols(4'b0111, 1'b1, 40, "bounce_wait_c3");
        key_down = 16'd1 << (2*4 + 3);
        step($urandom_range(3, 10));
        key_down = '0;
        wait_cols(4'b0111, 1'b0, 40, "bounce_wait_leave");
        chk("bounce_resume_c0", cols, 4'b1110);
        step(30);
        chk("bounce_no_valid", valid_cnt - n0, 0);
        chk("bounce_not_held", key_held, 0);

        // r0 and r3 together on c0: lowest row wins
        key_down = (16'd1 << 0) | (16'd1 << 12);
        wait_valid(120, "multi_timeout", at);
        chk("multi_code", key_code, 4'h1);
        chk("multi_held", key_held, 1);
        step(20);
        key_down = '0;
        wait_held_low(60, "multi_release_timeout", at);
        chk("multi_release_latency", at - rows_rise_cyc, LAT);
        chk("multi_resume_c1", cols, 4'b1101);

        // "A" held 200 clocks past the first strobe
        n0 = valid_cnt;
        key_down = 16'd1 << 3;
        wait_valid(120, "hold_a_timeout", v0);
        step(200);
        key_down = '0;
        wait_held_low(60, "hold_a_release_timeout", at);
`ifdef KEY_REPEAT_EN
        chk("hold_a_valid_count", valid_cnt - n0, 4);
        chk("hold_a_last_repeat", last_valid_cyc - v0, 192);
`else
        chk("hold_a_valid_count", valid_cnt - n0, 1);
        chk("hold_a_last_valid", last_valid_cyc - v0, 0);
`endif
        chk("hold_a_code", last_valid_code, 4'hA);

        // reset asserted mid-HELD, key still down afterwards
        idx = $urandom_range(0, 15);
        if (LEGEND[idx] == 4'h0) idx = 5;
        key_down = 16'd1 << idx;
        wait_valid(120, "pre_reset_timeout", at);
        step(5);
        #2 reset = 1'b1;
        #1;
        chk("midreset_cols", cols, 4'b1110);
        chk("midreset_valid", key_valid, 0);
        chk("midreset_held", key_held, 0);
        chk("midreset_code", key_code, 4'h0);
        step(2);
        reset = 1'b0;
        wait_valid(120, "post_reset_timeout", at);
        chk("post_reset_code", key_code, LEGEND[idx]);
        chk("post_reset_held", key_held, 1);
        key_down = '0;
        wait_held_low(60, "post_reset_release_timeout", at);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
